// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - serial multiply-accumulate neuron stage with bias, rounding and Q1.6 saturation
module neuron_mac #(
  parameter int N_INPUTS = 4,
  parameter int ACC_W    = 20,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bias,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] x_in,
  input  logic [7:0] w_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] y_out,
  output logic       sat_flag,
  output logic       busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic signed [ACC_W-1:0] R_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] R_MIN = -ACC_W'(128);

  logic [1:0]              state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        count;

  logic signed [7:0]       x_s;
  logic signed [7:0]       w_s;
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] acc_rnd;
  logic signed [ACC_W-1:0] r;
  logic                    accept;
  logic                    last_beat;

  assign x_s      = x_in;
  assign w_s      = w_in;
  assign prod     = x_s * w_s;
  assign prod_ext = {{(ACC_W-16){prod[15]}}, prod};
  // Q1.6 bias aligned to the Q2.12 product scale
  assign bias_ext = {{(ACC_W-14){bias[7]}}, bias, 6'b000000};

  assign acc_rnd  = acc + ACC_W'(32);
  assign r        = acc_rnd >>> 6;

  assign in_ready  = (state == S_IDLE) || (state == S_ACCUM);
  assign busy      = (state != S_IDLE);
  assign accept    = in_valid && in_ready;
  assign last_beat = (count == CNT_W'(N_INPUTS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      count     <= '0;
      y_out     <= 8'h00;
      sat_flag  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            acc   <= bias_ext + prod_ext;
            count <= CNT_W'(1);
            state <= (N_INPUTS == 1) ? S_ROUND : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            acc   <= acc + prod_ext;
            count <= count + CNT_W'(1);
            if (last_beat) state <= S_ROUND;
          end
        end
        S_ROUND: begin
          if (r > R_MAX) begin
            y_out    <= 8'h7F;
            sat_flag <= 1'b1;
          end else if (r < R_MIN) begin
            y_out    <= 8'h80;
            sat_flag <= 1'b1;
          end else begin
            y_out    <= r[7:0];
            sat_flag <= 1'b0;
          end
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        default: begin
          // result stays registered and stable until the consumer takes it
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - directed and randomized scoreboard bench for neuron_mac
module tb_neuron_mac;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bias = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] x_in = 8'h00;
  logic [7:0] w_in = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] y_out;
  logic       sat_flag;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  logic signed [7:0] bx [4];
  logic signed [7:0] bw [4];
  logic [8:0]        exp_q [$];

  neuron_mac #(.N_INPUTS(4), .ACC_W(20), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .bias(bias), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .w_in(w_in), .out_valid(out_valid), .out_ready(out_ready),
    .y_out(y_out), .sat_flag(sat_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: exact integer sum, floor shift, clip to Q1.6
  function automatic logic [8:0] model(input logic [7:0] b);
    int acc;
    int r;
    int xi;
    int wi;
    acc = int'($signed(b)) * 64;
    for (int i = 0; i < 4; i++) begin
      xi = bx[i];
      wi = bw[i];
      acc += xi * wi;
    end
    r = (acc + 32) >>> 6;
    if (r > 127) return {1'b1, 8'h7F};
    if (r < -128) return {1'b1, 8'h80};
    return {1'b0, 8'(r)};
  endfunction

  task automatic drive_beat(input logic [7:0] x, input logic [7:0] w, input logic [7:0] b, input int gaps);
    in_valid = 1'b0;
    repeat (gaps) @(negedge clk);
    check("in_ready_before_beat", in_ready, 1);
    in_valid = 1'b1;
    x_in = x;
    w_in = w;
    bias = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_neuron(input logic [7:0] b, input int gap_max, input int hold);
    logic [7:0] y_hold;
    logic       s_hold;
    logic [8:0] exp_v;
    exp_q.push_back(model(b));
    for (int i = 0; i < 4; i++)
      drive_beat(bx[i], bw[i], b, (gap_max > 0) ? $urandom_range(0, gap_max) : 0);
    check("round_out_valid_low", out_valid, 0);
    check("round_in_ready_low", in_ready, 0);
    @(negedge clk);
    check("latency_out_valid", out_valid, 1);
    y_hold = y_out;
    s_hold = sat_flag;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      check("hold_y_stable", y_out, y_hold);
      check("hold_sat_stable", sat_flag, s_hold);
      check("hold_in_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    check("out_valid_at_pop", out_valid, 1);
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      exp_v = exp_q.pop_front();
      check("y_out", y_out, exp_v[7:0]);
      check("sat_flag", sat_flag, exp_v[8]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_handshake_out_valid", out_valid, 0);
    check("post_handshake_in_ready", in_ready, 1);
  endtask

  task automatic set_beats(input logic [7:0] x0, w0, x1, w1, x2, w2, x3, w3);
    bx[0] = x0; bw[0] = w0; bx[1] = x1; bw[1] = w1;
    bx[2] = x2; bw[2] = w2; bx[3] = x3; bw[3] = w3;
  endtask

  initial begin
    // reset state
    #2;
    check("reset_y_out", y_out, 8'h00);
    check("reset_out_valid", out_valid, 0);
    check("reset_sat_flag", sat_flag, 0);
    check("reset_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);

    // reset mid-neuron after two beats discards the partial sum
    drive_beat(8'd100, 8'd100, 8'h3F, 0);
    drive_beat(8'd100, 8'd100, 8'h3F, 0);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_y_out", y_out, 8'h00);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    set_beats(8'd10, 8'd20, 8'd30, 8'hF0, 8'd5, 8'd64, 8'd0, 8'd0);
    run_neuron(8'h02, 0, 0);

    // nominal: 4 * 0.5 * -1.0 = -2.0 rounds to -128
    set_beats(8'd32, 8'hC0, 8'd32, 8'hC0, 8'd32, 8'hC0, 8'd32, 8'hC0);
    run_neuron(8'h00, 0, 0);
    // positive saturation
    set_beats(8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64);
    run_neuron(8'h40, 0, 0);
    // negative saturation
    set_beats(8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F);
    run_neuron(8'hC0, 0, 0);
    // rounding half-up
    set_beats(8'd1, 8'd32, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    run_neuron(8'h00, 0, 0);
    set_beats(8'hFF, 8'd32, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    run_neuron(8'h00, 0, 0);
    set_beats(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    run_neuron(8'h05, 0, 0);

    // handshake stress with random gaps and back-pressure
    for (int n = 0; n < 50; n++) begin
      for (int i = 0; i < 4; i++) begin
        bx[i] = 8'($urandom);
        bw[i] = 8'($urandom);
      end
      run_neuron(8'($urandom), 3, (n == 0) ? 5 : $urandom_range(0, 5));
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
